// File: rtl/effects_controller.sv
// Audio effects controller: buffers incoming samples in a small FIFO, hands each one to the
// effect stage, and forwards the selected result (or the raw sample on timeout) to the transmitter.
module effects_controller #(
  parameter int d_width    = 16,
  parameter int fifo_depth = 4,
  parameter int timeout    = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sample_valid,
  input  logic [d_width-1:0] i_sample,
  input  logic [1:0]         sw,
  output logic               o_data_ready,
  output logic [d_width-1:0] o_data,
  input  logic               i_read_enable,
  output logic               o_read_done,
  input  logic               i_data_valid,
  input  logic [d_width-1:0] i_data_sw0,
  input  logic [d_width-1:0] i_data_sw1,
  output logic [d_width-1:0] o_sample,
  output logic               o_sample_valid,
  output logic [7:0]         o_overflow_cnt,
  output logic               o_timeout
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = $clog2(timeout + 1);

  typedef enum logic [2:0] {S_IDLE, S_OFFER, S_DONE, S_WAIT, S_OUT} state_t;

  state_t             r_state;
  logic [d_width-1:0] r_mem [fifo_depth];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [7:0]         r_overflow_cnt;
  logic               r_data_ready;
  logic [d_width-1:0] r_data;
  logic               r_read_done;
  logic [d_width-1:0] r_raw;
  logic [CW-1:0]      r_wait_cnt;
  logic [d_width-1:0] r_sample;
  logic               r_sample_valid;
  logic               r_timeout;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [d_width-1:0] w_head;
  logic [d_width-1:0] w_selected;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = (r_state == S_OFFER) && i_read_enable;
  assign w_push  = i_sample_valid && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign w_selected = sw[1] ? i_data_sw1 :
                      sw[0] ? i_data_sw0 : r_raw;

  // NOTE: sample storage has no reset; the FIFO is defined empty by its pointers alone,
  // and every externally visible value comes from a reset register.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_sample;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_overflow_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (i_sample_valid && !w_push && (r_overflow_cnt != 8'hFF))
        r_overflow_cnt <= r_overflow_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_data_ready   <= 1'b0;
      r_data         <= '0;
      r_read_done    <= 1'b0;
      r_raw          <= '0;
      r_wait_cnt     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state      <= S_OFFER;
            r_data_ready <= 1'b1;
            r_data       <= w_head;
          end
        end
        S_OFFER: begin
          if (i_read_enable) begin
            r_raw        <= w_head;
            r_data_ready <= 1'b0;
            r_read_done  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_read_done <= 1'b0;
          r_wait_cnt  <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_data_valid) begin
            r_sample       <= w_selected;
            r_sample_valid <= 1'b1;
            r_state        <= S_OUT;
          end else if (r_wait_cnt == CW'(timeout - 1)) begin
            r_wait_cnt     <= r_wait_cnt + CW'(1);
            r_sample       <= r_raw;
            r_sample_valid <= 1'b1;
            r_timeout      <= 1'b1;
            r_state        <= S_OUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_OUT: begin
          r_sample_valid <= 1'b0;
          // Fold the IDLE check in here so back-to-back samples complete every 4 cycles.
          if (!w_empty) begin
            r_state      <= S_OFFER;
            r_data_ready <= 1'b1;
            r_data       <= w_head;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_ready   = r_data_ready;
  assign o_data         = r_data;
  assign o_read_done    = r_read_done;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
  assign o_overflow_cnt = r_overflow_cnt;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_effects_controller.sv
// Scoreboard bench for effects_controller: stimulus pushes expected samples into a queue,
// a negedge monitor pops and compares on every o_sample_valid strobe.
module tb_effects_controller;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_sample_valid = 1'b0;
  logic [DW-1:0] i_sample = '0;
  logic [1:0]    sw = 2'b00;
  logic          o_data_ready;
  logic [DW-1:0] o_data;
  logic          i_read_enable = 1'b0;
  logic          o_read_done;
  logic          i_data_valid = 1'b0;
  logic [DW-1:0] i_data_sw0 = '0;
  logic [DW-1:0] i_data_sw1 = '0;
  logic [DW-1:0] o_sample;
  logic          o_sample_valid;
  logic [7:0]    o_overflow_cnt;
  logic          o_timeout;

  effects_controller #(
    .d_width   (DW),
    .fifo_depth(DEPTH),
    .timeout   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_sample_valid(i_sample_valid),
    .i_sample      (i_sample),
    .sw            (sw),
    .o_data_ready  (o_data_ready),
    .o_data        (o_data),
    .i_read_enable (i_read_enable),
    .o_read_done   (o_read_done),
    .i_data_valid  (i_data_valid),
    .i_data_sw0    (i_data_sw0),
    .i_data_sw1    (i_data_sw1),
    .o_sample      (o_sample),
    .o_sample_valid(o_sample_valid),
    .o_overflow_cnt(o_overflow_cnt),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q[$];
  int            strobe_q[$];
  int            offer_q[$];
  int            n_done = 0;
  int            done_cyc = 0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus; compares every strobe against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (o_read_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (o_data_ready && !prev_ready) offer_q.push_back(cyc);
      prev_ready = o_data_ready;
      if (o_sample_valid) begin
        strobe_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_strobe", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("o_sample", {16'h0, o_sample}, {16'h0, mon_exp});
        end
      end
    end else begin
      prev_ready = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    i_sample_valid = 1'b1;
    i_sample       = v;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic serve(input logic [DW-1:0] head, input logic [DW-1:0] exp, input bit give_dv,
                       input int dv_delay, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    exp_q.push_back(exp);
    for (int k = 0; k < 100 && !o_data_ready; k++) tick();
    check("offer_ready", {31'h0, o_data_ready}, 32'd1);
    check("offer_head", {16'h0, o_data}, {16'h0, head});
    i_read_enable = 1'b1;
    tick();
    i_read_enable = 1'b0;
    repeat (dv_delay) tick();
    if (give_dv) begin
      i_data_valid = 1'b1;
      i_data_sw0   = d0;
      i_data_sw1   = d1;
    end
    for (int k = 0; k < TMO + 20 && !o_sample_valid; k++) tick();
    check("strobe_seen", {31'h0, o_sample_valid}, 32'd1);
    i_data_valid = 1'b0;
    tick();
  endtask

  logic [DW-1:0] stream_v [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
  logic [DW-1:0] ovf_v    [6] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};

  initial begin
    int n0;
    int sb;
    int ob;
    int j;

    // Reset state
    repeat (3) tick();
    check("rst_data_ready", {31'h0, o_data_ready}, 32'd0);
    check("rst_data", {16'h0, o_data}, 32'd0);
    check("rst_read_done", {31'h0, o_read_done}, 32'd0);
    check("rst_sample", {16'h0, o_sample}, 32'd0);
    check("rst_sample_valid", {31'h0, o_sample_valid}, 32'd0);
    check("rst_overflow", {24'h0, o_overflow_cnt}, 32'd0);
    check("rst_timeout", {31'h0, o_timeout}, 32'd0);
    reset = 1'b1;
    tick();

    // No-effect path, result two cycles after the read handshake
    sw = 2'b01;
    n0 = n_done;
    push(16'h1234);
    serve(16'h1234, 16'h1234, 1'b1, 2, 16'h1234, 16'hAAAA);
    repeat (3) tick();
    check("read_done_pulses", n_done - n0, 32'd1);

    // Clipping, bypass, and sw[1] priority over sw[0]
    sw = 2'b10;
    push(16'h7000);
    serve(16'h7000, 16'h0FFF, 1'b1, 0, 16'h5555, 16'h0FFF);
    sw = 2'b00;
    push(16'h7000);
    serve(16'h7000, 16'h7000, 1'b1, 1, 16'h1111, 16'h2222);
    repeat (5) tick();
    check("sample_hold", {16'h0, o_sample}, 32'h7000);
    check("valid_low_between", {31'h0, o_sample_valid}, 32'd0);
    sw = 2'b11;
    push(16'h0101);
    serve(16'h0101, 16'h0BAD, 1'b1, 0, 16'h0CAB, 16'h0BAD);
    repeat (3) tick();

    // Streaming with zero-wait handshakes: push-on-full coinciding with a pop is accepted
    sw = 2'b00;
    sb = strobe_q.size();
    ob = offer_q.size();
    for (int i = 0; i < 6; i++) exp_q.push_back(stream_v[i]);
    i_read_enable = 1'b1;
    i_data_valid  = 1'b1;
    j = 0;
    for (int i = 0; i < 7; i++) begin
      if (i != 5) begin
        i_sample_valid = 1'b1;
        i_sample       = stream_v[j];
        j++;
      end else begin
        i_sample_valid = 1'b0;
      end
      tick();
    end
    i_sample_valid = 1'b0;
    check("stream_no_drop", {24'h0, o_overflow_cnt}, 32'd0);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    check("stream_drain", exp_q.size(), 32'd0);
    i_read_enable = 1'b0;
    i_data_valid  = 1'b0;
    repeat (3) tick();
    check("stream_overflow", {24'h0, o_overflow_cnt}, 32'd0);
    for (int i = 1; i < 6; i++)
      check("stream_interval", strobe_q[sb+i] - strobe_q[sb+i-1], 32'd4);
    for (int i = 0; i < 6; i++)
      check("stream_latency", strobe_q[sb+i] - offer_q[ob+i], 32'd3);

    // Overflow: effect stage stalled, six pushes into four entries, then saturation
    for (int i = 0; i < 6; i++) push(ovf_v[i]);
    check("overflow_two", {24'h0, o_overflow_cnt}, 32'd2);
    for (int i = 0; i < 260; i++) push(16'hDEAD);
    check("overflow_saturate", {24'h0, o_overflow_cnt}, 32'd255);
    for (int i = 0; i < 4; i++) serve(ovf_v[i], ovf_v[i], 1'b1, 0, 16'h1111, 16'h2222);
    repeat (3) tick();
    check("fifo_empty_after", {31'h0, o_data_ready}, 32'd0);

    // Result timeout falls back to the raw sample
    sw = 2'b01;
    check("timeout_clear", {31'h0, o_timeout}, 32'd0);
    push(16'h8001);
    serve(16'h8001, 16'h8001, 1'b0, 0, 16'h0, 16'h0);
    check("timeout_latency", strobe_q[$] - done_cyc, TMO + 1);
    check("timeout_flag", {31'h0, o_timeout}, 32'd1);

    // Reset during WAIT abandons the sample without strobes
    push(16'h4321);
    for (int k = 0; k < 100 && !o_data_ready; k++) tick();
    check("abort_offer", {31'h0, o_data_ready}, 32'd1);
    i_read_enable = 1'b1;
    tick();
    i_read_enable = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_data_ready", {31'h0, o_data_ready}, 32'd0);
    check("midrst_data", {16'h0, o_data}, 32'd0);
    check("midrst_read_done", {31'h0, o_read_done}, 32'd0);
    check("midrst_sample", {16'h0, o_sample}, 32'd0);
    check("midrst_sample_valid", {31'h0, o_sample_valid}, 32'd0);
    check("midrst_overflow", {24'h0, o_overflow_cnt}, 32'd0);
    check("midrst_timeout", {31'h0, o_timeout}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("postrst_idle", {31'h0, o_data_ready}, 32'd0);
    push(16'h2468);
    serve(16'h2468, 16'h2468, 1'b1, 1, 16'h2468, 16'h9999);
    check("postrst_timeout", {31'h0, o_timeout}, 32'd0);

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
